// File: rtl/mem_access_stage.sv
// Purpose: memory-access pipeline stage. It drives a req/gnt/rvalid data port, aligns and
//          extends load data, and registers the MEM/WB payload.
// Latency: a store granted in its first cycle retires with no stall. The fastest load is one
//          address cycle with gnt, then one cycle with rvalid, and its result is in WB one clk later.
// Backpressure: stall_MEM is high while a legal memory op has not completed. WB takes a bubble
//          while stalled. At most one transaction is outstanding.
// Ports:
//   clk, rst                   : clock and synchronous active-low reset
//   *_MEM inputs               : registered EX/MEM operands and controls
//   dmem_* outputs and inputs  : 8-byte data-memory port (req/gnt for address, rvalid/rdata for loads)
//   stall_MEM                  : freezes the upstream pipeline
//   wb_* outputs               : registered MEM/WB payload
module mem_access_stage #(
  parameter int XLEN  = 64,
  parameter int RID_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_MEM,
  input  logic [RID_W-1:0] rd_MEM,
  input  logic             is_load_MEM,
  input  logic             is_store_MEM,
  input  logic [1:0]       size_MEM,
  input  logic             unsigned_MEM,
  input  logic [XLEN-1:0]  alu_result_MEM,
  input  logic [XLEN-1:0]  rdata_2_MEM,
  input  logic [XLEN-1:0]  pc_MEM,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [7:0]       dmem_wmask,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             stall_MEM,
  output logic             wb_valid,
  output logic [RID_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_misalign,
  output logic [XLEN-1:0]  wb_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_mem_op;
  logic            w_misalign;
  logic            w_go;
  logic            w_complete;
  logic            w_load_done;
  logic [2:0]      w_off;
  logic [5:0]      w_shamt;
  logic [7:0]      w_size_mask;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_data;
  logic [XLEN-1:0] w_wb_data;

  assign w_mem_op = ~flush_MEM & (is_load_MEM | is_store_MEM);
  assign w_off    = alu_result_MEM[2:0];
  assign w_shamt  = {w_off, 3'b000};

  // The access must be naturally aligned to its own size.
  always_comb begin
    w_misalign  = 1'b0;
    w_size_mask = 8'h01;
    case (size_MEM)
      2'd0: begin w_misalign = 1'b0;        w_size_mask = 8'h01; end
      2'd1: begin w_misalign = w_off[0];    w_size_mask = 8'h03; end
      2'd2: begin w_misalign = |w_off[1:0]; w_size_mask = 8'h0F; end
      default: begin w_misalign = |w_off;   w_size_mask = 8'hFF; end
    endcase
    w_misalign = w_misalign & w_mem_op;
  end

  assign w_go = w_mem_op & ~w_misalign;

  // Address, data and mask come from the held EX/MEM operands, so they stay stable
  // for as long as the request is pending.
  assign dmem_we    = is_store_MEM & w_mem_op;
  assign dmem_addr  = {alu_result_MEM[XLEN-1:3], 3'b000};
  assign dmem_wdata = rdata_2_MEM << w_shamt;
  assign dmem_wmask = w_size_mask << w_off;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A load leaves the address phase for WAIT. A store completes in the cycle it is granted.
  always_comb begin
    w_state_nxt = r_state;
    dmem_req    = 1'b0;
    w_complete  = 1'b0;
    w_load_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_go) begin
          dmem_req = 1'b1;
          if (dmem_gnt) begin
            if (is_load_MEM) w_state_nxt = WAIT;
            else             w_complete  = 1'b1;
          end else begin
            w_state_nxt = REQ;
          end
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          if (is_load_MEM) begin
            w_state_nxt = WAIT;
          end else begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          w_complete  = 1'b1;
          w_load_done = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign stall_MEM = w_go & ~w_complete;

  // Shift the addressed lane down to bit 0, then extend it to full width.
  assign w_shifted = dmem_rdata >> w_shamt;

  always_comb begin
    w_load_data = w_shifted;
    case (size_MEM)
      2'd0: w_load_data = unsigned_MEM ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                       : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      2'd1: w_load_data = unsigned_MEM ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                       : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      2'd2: w_load_data = unsigned_MEM ? {{(XLEN-32){1'b0}}, w_shifted[31:0]}
                                       : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  assign w_wb_data = w_load_done ? w_load_data :
                     w_misalign  ? '0          : alu_result_MEM;

  // While stalled, WB takes a bubble and the remaining fields hold their values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_misalign <= 1'b0;
      wb_pc       <= '0;
    end else if (stall_MEM) begin
      wb_valid    <= 1'b0;
    end else begin
      wb_valid    <= ~flush_MEM;
      wb_rd       <= rd_MEM;
      wb_pc       <= pc_MEM;
      wb_misalign <= w_misalign;
      wb_data     <= w_wb_data;
    end
  end

endmodule
